// File: rtl/vin_axi4s.sv
// rtl/vin_axi4s.sv - video timing (vsync/de/data) to AXI4-Stream receiver with overflow-safe FIFO
// Optional feature macro: VIN_AXI4S_FRAME_COUNT_EN adds out_frame_count.
module vin_axi4s #(
  parameter int WIDTH          = 24,
  parameter int FIFO_PTR_WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_de,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ovf_clear,
  output logic             m_axi4s_tuser,
  output logic             m_axi4s_tlast,
  output logic [WIDTH-1:0] m_axi4s_tdata,
  output logic             m_axi4s_tvalid,
  input  logic             m_axi4s_tready,
  output logic             out_overflow
`ifdef VIN_AXI4S_FRAME_COUNT_EN
  ,
  output logic [15:0]      out_frame_count
`endif
);

  localparam int DEPTH = 2 ** FIFO_PTR_WIDTH;
  localparam int EW    = WIDTH + 2;
  localparam logic [FIFO_PTR_WIDTH:0] PTR_ONE = {{FIFO_PTR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_WAIT_FS, ST_RUN, ST_DROP} state_t;
  state_t r_state, w_state_nxt;

  logic                    r_vsync, r_hsync, r_de;
  logic [WIDTH-1:0]        r_data;
  logic                    r_flag_fs, r_overflow;
  logic [FIFO_PTR_WIDTH:0] r_wr_ptr, r_rd_ptr;
  logic [EW-1:0]           r_mem [DEPTH];
  logic                    r_tvalid, r_tuser, r_tlast;
  logic [WIDTH-1:0]        r_tdata;

  logic          w_fs_edge, w_px_tuser, w_px_tlast;
  logic          w_full, w_empty, w_rd_en, w_room;
  logic          w_wr_en, w_ovf_set;
  logic [EW-1:0] w_rd_entry;
  logic          w_unused;

  // hsync is captured only so it can be probed; it takes no part in framing
  assign w_unused = r_hsync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_de    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_vsync <= in_vsync;
      r_hsync <= in_hsync;
      r_de    <= in_de;
      r_data  <= in_data;
    end
  end

  assign w_fs_edge  = in_vsync != r_vsync;
  assign w_px_tuser = r_flag_fs;
  assign w_px_tlast = r_de & ~in_de;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_flag_fs <= 1'b0;
    else if (w_fs_edge) r_flag_fs <= 1'b1;
    else if (r_de)      r_flag_fs <= 1'b0;
  end

  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign w_full  = (r_wr_ptr[FIFO_PTR_WIDTH] != r_rd_ptr[FIFO_PTR_WIDTH]) &&
                   (r_wr_ptr[FIFO_PTR_WIDTH-1:0] == r_rd_ptr[FIFO_PTR_WIDTH-1:0]);
  assign w_rd_en = (~r_tvalid | m_axi4s_tready) & ~w_empty;
  // a full FIFO still accepts a pixel when the output stage pops in the same cycle
  assign w_room  = ~w_full | w_rd_en;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_de) begin
          if (w_room) begin
            w_wr_en = 1'b1;
          end else begin
            w_ovf_set   = 1'b1;
            w_state_nxt = ST_DROP;
          end
        end
      end
      default: begin
        if (r_de && w_px_tuser) begin
          if (w_room) begin
            w_wr_en     = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_ovf_set   = 1'b1;
            w_state_nxt = ST_DROP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_WAIT_FS;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[FIFO_PTR_WIDTH-1:0]] <= {w_px_tuser, w_px_tlast, r_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign w_rd_entry = r_mem[r_rd_ptr[FIFO_PTR_WIDTH-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (~r_tvalid | m_axi4s_tready) begin
      r_tvalid <= ~w_empty;
      if (~w_empty) {r_tuser, r_tlast, r_tdata} <= w_rd_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (ovf_clear) r_overflow <= 1'b0;
  end

`ifdef VIN_AXI4S_FRAME_COUNT_EN
  logic [15:0] r_frame_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_frame_count <= '0;
    else if (w_wr_en && w_px_tuser)  r_frame_count <= r_frame_count + 16'd1;
  end
  assign out_frame_count = r_frame_count;
`endif

  assign m_axi4s_tvalid = r_tvalid;
  assign m_axi4s_tuser  = r_tuser;
  assign m_axi4s_tlast  = r_tlast;
  assign m_axi4s_tdata  = r_tdata;
  assign out_overflow   = r_overflow;

endmodule

// File: tb/tb_vin_axi4s.sv
// tb/tb_vin_axi4s.sv - randomized and directed bench for vin_axi4s against a queue-based frame model
module tb_vin_axi4s;
  localparam int W     = 24;
  localparam int PW    = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_vsync = 1'b0, in_hsync = 1'b0, in_de = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         ovf_clear = 1'b0;
  logic         tuser, tlast, tvalid, ovf;
  logic [W-1:0] tdata;
  logic         tready = 1'b1;
`ifdef VIN_AXI4S_FRAME_COUNT_EN
  logic [15:0]  fcnt;
`endif

  always #5 clk = ~clk;

  vin_axi4s #(.WIDTH(W), .FIFO_PTR_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .in_data(in_data), .ovf_clear(ovf_clear), .m_axi4s_tuser(tuser), .m_axi4s_tlast(tlast),
    .m_axi4s_tdata(tdata), .m_axi4s_tvalid(tvalid), .m_axi4s_tready(tready), .out_overflow(ovf)
`ifdef VIN_AXI4S_FRAME_COUNT_EN
    , .out_frame_count(fcnt)
`endif
  );

  typedef struct packed {logic u; logic l; logic [W-1:0] d;} beat_t;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int first_tv_cyc = -1;
  int lo = -1, hi = -1;
  bit rnd_ready = 1'b0;
  bit ready_force0 = 1'b0;
  beat_t beats[$];

  beat_t        mq[$];
  beat_t        m_out;
  bit           m_valid, m_vs, m_de, m_fs, m_acc, m_ovf;
  logic [W-1:0] m_data;
  logic [15:0]  m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_out = '0; m_vs = 0; m_de = 0; m_data = '0;
    m_fs = 0; m_acc = 0; m_ovf = 0; m_cnt = '0;
  endtask

  // Frame model: a pixel is kept if we are locked to a frame or it opens one;
  // it is lost (and the lock dropped) when the buffer has no space after this cycle's pop.
  task automatic model_step();
    bit    pop, room, ovf_set;
    beat_t px;
    if (!reset) begin
      model_reset();
    end else begin
      pop     = (!m_valid || tready) && mq.size() > 0;
      room    = (mq.size() - (pop ? 1 : 0)) < DEPTH;
      ovf_set = 0;
      if (!m_valid || tready) begin
        if (pop) begin
          m_out   = mq.pop_front();
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      if (m_de && (m_acc || m_fs)) begin
        px = {m_fs, ~in_de, m_data};
        if (room) begin
          mq.push_back(px);
          m_acc = 1;
          if (m_fs) m_cnt = m_cnt + 16'd1;
        end else begin
          ovf_set = 1;
          m_acc   = 0;
        end
      end
      if (in_vsync != m_vs) m_fs = 1;
      else if (m_de)        m_fs = 0;
      if (ovf_set)        m_ovf = 1;
      else if (ovf_clear) m_ovf = 0;
      m_vs = in_vsync; m_de = in_de; m_data = in_data;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      check("tvalid", tvalid, m_valid);
      if (m_valid) begin
        check("tdata", tdata, m_out.d);
        check("tuser", tuser, m_out.u);
        check("tlast", tlast, m_out.l);
      end
      check("overflow", ovf, m_ovf);
`ifdef VIN_AXI4S_FRAME_COUNT_EN
      check("frame_count", fcnt, m_cnt);
`endif
      if (tvalid && first_tv_cyc < 0) first_tv_cyc <= cyc;
      if (tvalid && tready) beats.push_back({tuser, tlast, tdata});
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (ready_force0)   tready = 1'b0;
    else if (rnd_ready) tready = ($urandom_range(0, 1) == 1);
    else                tready = !(cyc >= lo && cyc <= hi);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic toggle();
    in_vsync = ~in_vsync;
    step();
  endtask

  task automatic send_line(input int base, input int len, input int clr_at);
    for (int i = 0; i < len; i++) begin
      in_de = 1'b1;
      in_data = W'(base + i);
      ovf_clear = (i == clr_at);
      step();
    end
    in_de = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic check_beats(input string nm, input int n, input int base, input int linelen);
    int errs;
    errs = 0;
    check({nm, "_count"}, beats.size(), n);
    if (beats.size() == n) begin
      for (int i = 0; i < n; i++)
        if (beats[i].d !== W'(base + i) || beats[i].u !== (i == 0) ||
            beats[i].l !== ((i % linelen) == linelen - 1)) errs++;
      check({nm, "_beats"}, errs, 0);
    end
  endtask

  initial begin
    int c, nl, len, gap, nu;
    model_reset();
    idle(3);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;
    idle(2);

    beats.delete();
    send_line(100, 6, -1); idle(2); send_line(200, 6, -1); idle(10);
    check("prevsync_beats", beats.size(), 0);

    beats.delete();
    first_tv_cyc = -1;
    toggle();
    c = cyc;
    send_line(1, 4, -1); idle(2); send_line(5, 4, -1); idle(12);
    check_beats("frame1", 8, 1, 4);
    check("frame1_latency", first_tv_cyc - c, 3);

    beats.delete();
    toggle();
    c = cyc;
    lo = c + 4; hi = c + 7;
    send_line(1, 4, -1); idle(2); send_line(5, 4, -1); idle(14);
    lo = -1; hi = -1;
    check_beats("stall", 8, 1, 4);
    check("stall_no_ovf", ovf, 0);

    beats.delete();
    ready_force0 = 1'b1;
    toggle();
    send_line(1, 8, -1); idle(5);
    check("ovf_set", ovf, 1);
    check("model_ovf", m_ovf, 1);
    ready_force0 = 1'b0;
    idle(20);
    check_beats("ovf_drain", 5, 1, 8);
    beats.delete();
    send_line(9, 8, -1); idle(15);
    check("drop_until_fs", beats.size(), 0);
    toggle();
    send_line(20, 4, -1); idle(12);
    check_beats("after_ovf", 4, 20, 4);

    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("ovf_clear", ovf, 0);
    idle(2);

    ready_force0 = 1'b1;
    toggle();
    send_line(1, 8, 6); idle(3);
    check("ovf_clear_vs_set", ovf, 1);
    ready_force0 = 1'b0;
    idle(20);
    ovf_clear = 1'b1; step(); ovf_clear = 1'b0;

    rnd_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      toggle();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        len = $urandom_range(1, 10);
        for (int p = 0; p < len; p++) begin
          in_de = 1'b1;
          in_data = W'($urandom);
          ovf_clear = ($urandom_range(0, 15) == 0);
          step();
        end
        in_de = 1'b0;
        ovf_clear = 1'b0;
        gap = $urandom_range(1, 4);
        idle(gap);
      end
      idle($urandom_range(0, 6));
    end
    rnd_ready = 1'b0;
    idle(20);

    ready_force0 = 1'b1;
    toggle();
    for (int i = 0; i < 5; i++) begin
      in_de = 1'b1;
      in_data = W'(60 + i);
      step();
    end
    check("pre_reset_tvalid", tvalid, 1);
    reset = 1'b0;
    in_de = 1'b0;
    #1;
    check("async_tvalid", tvalid, 0);
    check("async_tuser", tuser, 0);
    check("async_tlast", tlast, 0);
    check("async_tdata", tdata, 0);
    check("async_ovf", ovf, 0);
`ifdef VIN_AXI4S_FRAME_COUNT_EN
    check("async_count", fcnt, 0);
`endif
    model_reset();
    ready_force0 = 1'b0;
    idle(2);
    reset = 1'b1;
    beats.delete();
    idle(2);
    for (int f = 0; f < 3; f++) begin
      toggle();
      send_line(50, 2, -1); idle(1); send_line(52, 2, -1); idle(8);
    end
    nu = 0;
    foreach (beats[i]) if (beats[i].u) nu++;
    check("three_frames_tuser", nu, 3);
    check("three_frames_beats", beats.size(), 12);
`ifdef VIN_AXI4S_FRAME_COUNT_EN
    check("three_frames_count", fcnt, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
